fetch_resp_ctrl: RTL

Multi-channel fetch responder generalising the single fetch/req/ack/cache_hit/data_ready handshake to NUM_CH independent channels with a parametrised ack window. Each fetch is served either as a cache hit (data_ready one cycle later) or as a miss (req raised until ack arrives inside [MIN_LAT, MAX_LAT]). Early acks and timeouts are flagged, and aggregate event counters are kept. It sits between fetch initiators and the backing memory port and serves as the RTL target for the chapter's or/vacuity property set.

---
 rtl/fetch_resp_pkg.sv | 20 ++
 rtl/fetch_resp_chan.sv | 109 ++++++++++
 rtl/fetch_resp_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/fetch_resp_pkg.sv
// Shared types and sizing helpers for the multi-channel fetch responder.
package fetch_resp_pkg;

    // Per-channel controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIT  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    // Width needed for a latency counter that must hold values 0..max_lat.
    function automatic int unsigned lat_width(input int unsigned max_lat);
        return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
    endfunction

    // Default ack window upper bound and the counter width it implies.
    localparam int unsigned DEF_MAX_LAT = 5;
    localparam int unsigned DEF_LAT_W   = lat_width(DEF_MAX_LAT);

endpackage

// File: rtl/fetch_resp_chan.sv
// One fetch channel: serves a hit directly or tracks a miss through its ack window.
module fetch_resp_chan
    import fetch_resp_pkg::*;
#(
    parameter int unsigned MIN_LAT = 1,
    parameter int unsigned MAX_LAT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic fetch,
    input  logic cache_hit,
    input  logic ack,
    output logic req,
    output logic data_ready,
    output logic done,
    output logic ok,
    output logic err_early,
    output logic err_timeout,
    output logic busy
);

    localparam int unsigned LAT_W = lat_width(MAX_LAT);

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [LAT_W-1:0] lat_q;
    logic [LAT_W-1:0] lat_d;
    logic             data_ready_d;
    logic             done_d;
    logic             ok_d;
    logic             err_early_d;
    logic             err_timeout_d;

    // Next-state, latency count and completion pulses for this channel.
    always_comb begin
        state_d       = state_q;
        lat_d         = lat_q;
        data_ready_d  = 1'b0;
        done_d        = 1'b0;
        ok_d          = 1'b0;
        err_early_d   = 1'b0;
        err_timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch) begin
                    if (cache_hit) begin
                        state_d      = HIT;
                        data_ready_d = 1'b1;
                        done_d       = 1'b1;
                    end else begin
                        state_d = WAIT;
                        lat_d   = LAT_W'(1);
                    end
                end
            end
            HIT: begin
                state_d = IDLE;
            end
            WAIT: begin
                if (ack) begin
                    state_d = IDLE;
                    lat_d   = '0;
                    if (lat_q < LAT_W'(MIN_LAT)) begin
                        err_early_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        ok_d   = 1'b1;
                    end
                end else if (lat_q == LAT_W'(MAX_LAT)) begin
                    state_d       = IDLE;
                    lat_d         = '0;
                    err_timeout_d = 1'b1;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                lat_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; req/busy follow the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            req         <= 1'b0;
            busy        <= 1'b0;
            data_ready  <= 1'b0;
            done        <= 1'b0;
            ok          <= 1'b0;
            err_early   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            req         <= (state_d == WAIT);
            busy        <= (state_d != IDLE);
            data_ready  <= data_ready_d;
            done        <= done_d;
            ok          <= ok_d;
            err_early   <= err_early_d;
            err_timeout <= err_timeout_d;
        end
    end

endmodule

// File: rtl/fetch_resp_ctrl.sv
// Multi-channel fetch responder with aggregate saturating event statistics.
module fetch_resp_ctrl
    import fetch_resp_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned MIN_LAT = 1,
    parameter int unsigned MAX_LAT = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] fetch,
    input  logic [NUM_CH-1:0] cache_hit,
    input  logic [NUM_CH-1:0] ack,
    output logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] data_ready,
    output logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] err_early,
    output logic [NUM_CH-1:0] err_timeout,
    output logic [NUM_CH-1:0] busy,
    output logic [CNT_W-1:0]  stat_hit,
    output logic [CNT_W-1:0]  stat_ok,
    output logic [CNT_W-1:0]  stat_err
);

    localparam int unsigned PC_W  = $clog2(NUM_CH + 1);
    localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_CH-1:0] ok;
    logic [PC_W-1:0]   pc_hit;
    logic [PC_W-1:0]   pc_ok;
    logic [PC_W-1:0]   pc_err;

    // Add an event count to a statistic, clamping at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [PC_W-1:0]  inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cnt) + SUM_W'(inc);
        if (sum > SUM_W'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return CNT_W'(sum);
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        fetch_resp_chan #(
            .MIN_LAT (MIN_LAT),
            .MAX_LAT (MAX_LAT)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .fetch       (fetch[g]),
            .cache_hit   (cache_hit[g]),
            .ack         (ack[g]),
            .req         (req[g]),
            .data_ready  (data_ready[g]),
            .done        (done[g]),
            .ok          (ok[g]),
            .err_early   (err_early[g]),
            .err_timeout (err_timeout[g]),
            .busy        (busy[g])
        );
    end

    // Per-cycle popcounts of the visible event pulses across all channels.
    always_comb begin
        pc_hit = '0;
        pc_ok  = '0;
        pc_err = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pc_hit = pc_hit + PC_W'(data_ready[i]);
            pc_ok  = pc_ok  + PC_W'(ok[i]);
            pc_err = pc_err + PC_W'(err_early[i] | err_timeout[i]);
        end
    end

    // Saturating statistics, updated the cycle after each pulse is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hit <= '0;
            stat_ok  <= '0;
            stat_err <= '0;
        end else begin
            stat_hit <= sat_add(stat_hit, pc_hit);
            stat_ok  <= sat_add(stat_ok,  pc_ok);
            stat_err <= sat_add(stat_err, pc_err);
        end
    end

endmodule
